// File: rtl/emu_host_sequencer.sv
// emu_host_sequencer: host-side initiator for the co-emulation wrapper bus.
// Collects one vector of stimulus bytes from a valid/ready stream and writes them into
// the wrapper's stimulus slots. It then loads them, pulses clk_dut once, captures the
// DUT outputs and streams the output slots back out on a valid/ready stream.
module emu_host_sequencer #(
    parameter int NUM_STIM_ARRAY = 1,
    parameter int NUM_OUT_ARRAY  = 1,
    parameter int ADDR_W         = 3,
    parameter int CLK_HI_CYC     = 2,
    parameter int CLK_LO_CYC     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        Din_emu,
    input  logic [7:0]        Dout_emu,
    output logic [ADDR_W-1:0] Addr_emu,
    output logic              load_emu,
    output logic              get_emu,
    output logic              clk_dut,
    output logic              busy,
    output logic [15:0]       vec_count
);

    // idx must be able to reach 2**ADDR_W after the last slot is used
    localparam int IDX_W  = ADDR_W + 1;
    localparam int PH_MAX = (CLK_HI_CYC > CLK_LO_CYC) ? CLK_HI_CYC : CLK_LO_CYC;
    localparam int CNT_W  = $clog2(PH_MAX + 1);

    localparam logic [IDX_W-1:0] STIM_LAST = IDX_W'(NUM_STIM_ARRAY - 1);
    localparam logic [IDX_W-1:0] OUT_LAST  = IDX_W'(NUM_OUT_ARRAY - 1);
    localparam logic [CNT_W-1:0] HI_LAST   = CNT_W'(CLK_HI_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(CLK_LO_CYC - 1);

    typedef enum logic [3:0] {
        S_WRITE, S_COMMIT, S_LOAD, S_CLK_HI, S_CLK_LO, S_GET, S_RADDR, S_RCAP, S_RPUSH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         din_q, din_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic [15:0]        vec_q, vec_d;
    logic               s_ready_q, load_q, get_q, clk_dut_q, busy_q;

    assign s_ready   = s_ready_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign Din_emu   = din_q;
    assign Addr_emu  = addr_q;
    assign load_emu  = load_q;
    assign get_emu   = get_q;
    assign clk_dut   = clk_dut_q;
    assign busy      = busy_q;
    assign vec_count = vec_q;

    // Next-state and datapath decisions for the vector sequence
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        addr_d    = addr_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        vec_d     = vec_q;
        case (state_q)
            S_WRITE: begin
                // s_ready_q is only ever high while in WRITE
                if (s_valid && s_ready_q) begin
                    din_d  = s_data;
                    addr_d = idx_q[ADDR_W-1:0];
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == STIM_LAST) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_CLK_HI;
            end
            S_CLK_HI: begin
                if (cnt_q == HI_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLK_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLK_LO: begin
                if (cnt_q == LO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GET;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GET: begin
                idx_d   = '0;
                addr_d  = '0;
                state_d = S_RADDR;
            end
            S_RADDR: state_d = S_RCAP;
            S_RCAP: begin
                // wrapper output register now holds the slot addressed during RADDR
                m_data_d  = Dout_emu;
                m_valid_d = 1'b1;
                state_d   = S_RPUSH;
            end
            S_RPUSH: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (idx_q == OUT_LAST) begin
                        idx_d   = '0;
                        vec_d   = vec_q + 16'd1;
                        state_d = S_WRITE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = idx_d[ADDR_W-1:0];
                        state_d = S_RADDR;
                    end
                end
            end
            default: state_d = S_WRITE;
        endcase
    end

    // State and datapath registers; reset abandons any vector in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_WRITE;
            idx_q     <= '0;
            cnt_q     <= '0;
            din_q     <= '0;
            addr_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            addr_q    <= addr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            vec_q     <= vec_d;
        end
    end

    // Strobes decoded from the next state and registered, so they are glitch-free and
    // line up with the state they belong to (and read 0 while reset is held)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready_q <= 1'b0;
            load_q    <= 1'b0;
            get_q     <= 1'b0;
            clk_dut_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s_ready_q <= (state_d == S_WRITE);
            load_q    <= (state_d == S_LOAD);
            get_q     <= (state_d == S_GET);
            clk_dut_q <= (state_d == S_CLK_HI);
            busy_q    <= !((state_d == S_WRITE) && (idx_d == '0));
        end
    end

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Testbench for emu_host_sequencer: a wrapper + emulated-DUT model on the bus side,
// random stimulus vectors on the host side, and a scoreboard on the output stream.
module tb_emu_host_sequencer;

    localparam int NS = 3;
    localparam int NO = 2;
    localparam int AW = 3;
    localparam int HI = 2;
    localparam int LO = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    Din_emu;
    logic [7:0]    Dout_emu;
    logic [AW-1:0] Addr_emu;
    logic          load_emu;
    logic          get_emu;
    logic          clk_dut;
    logic          busy;
    logic [15:0]   vec_count;

    always #5 clk = ~clk;

    emu_host_sequencer #(
        .NUM_STIM_ARRAY(NS), .NUM_OUT_ARRAY(NO), .ADDR_W(AW),
        .CLK_HI_CYC(HI), .CLK_LO_CYC(LO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .Din_emu(Din_emu), .Dout_emu(Dout_emu), .Addr_emu(Addr_emu),
        .load_emu(load_emu), .get_emu(get_emu), .clk_dut(clk_dut),
        .busy(busy), .vec_count(vec_count)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    int exp_vec = 0;
    logic vc_pending = 1'b0;
    int out_cnt = 0;

    // Behaviour of the emulated DUT: each output byte is a fixed mix of all inputs
    function automatic logic [7:0] ref_out(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input int j);
        logic [7:0] mix;
        mix = a + 8'(b * 3) + 8'(c * 5);
        return mix ^ 8'(j * 53 + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wrapper model: stimulus slots, applied inputs, captured outputs, registered read port
    logic [7:0] stim_mem[8];
    logic [7:0] out_mem[8];
    logic [7:0] dut_in[NS];
    logic [7:0] dut_out[NO];
    logic [7:0] dout_q = 8'h00;
    assign Dout_emu = dout_q;

    initial begin
        for (int i = 0; i < 8; i++) begin
            stim_mem[i] = 8'h00;
            out_mem[i]  = 8'h00;
        end
        for (int i = 0; i < NS; i++) dut_in[i] = 8'h00;
        for (int j = 0; j < NO; j++) dut_out[j] = 8'h00;
    end

    always @(posedge clk) begin
        if (!load_emu && !get_emu) stim_mem[Addr_emu] <= Din_emu;
        if (load_emu) for (int i = 0; i < NS; i++) dut_in[i] <= stim_mem[i];
        if (get_emu) for (int j = 0; j < NO; j++) out_mem[j] <= dut_out[j];
        dout_q <= out_mem[Addr_emu];
    end

    // Emulated DUT registers its outputs on the rising edge of clk_dut
    always begin
        @(posedge clk_dut);
        #1;
        for (int j = 0; j < NO; j++) dut_out[j] = ref_out(dut_in[0], dut_in[1], dut_in[2], j);
    end

    // Host-side consumer: random m_ready with occasional 5-cycle stalls
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge clk); #1;
            if (hold > 0) begin
                m_ready = 1'b0;
                hold--;
            end else if ($urandom_range(0, 9) == 0) begin
                m_ready = 1'b0;
                hold = 4;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: bus protocol checks and output-stream scoreboard
    int hi_run = 0, lo_run = 0, pulses = 0;
    logic prev_load = 1'b0, prev_get = 1'b0, have_prev = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (reset) begin
            hi_run = 0; lo_run = 0; pulses = 0; out_cnt = 0; exp_vec = 0;
            vc_pending = 1'b0; have_prev = 1'b0; prev_load = 1'b0; prev_get = 1'b0;
        end else begin
            checks++;
            if ((load_emu && get_emu) || (get_emu && clk_dut) || (load_emu && clk_dut)) begin
                errors++;
                $display("FAIL strobe_overlap: load=%b get=%b clk_dut=%b required no overlap",
                         load_emu, get_emu, clk_dut);
            end
            if (clk_dut) begin
                hi_run++;
                lo_run = 0;
            end else begin
                if (hi_run != 0) begin
                    chk("clk_dut_high_cycles", hi_run, HI);
                    pulses++;
                    hi_run = 0;
                end
                lo_run++;
            end
            if (load_emu) begin
                chk("load_width", prev_load, 0);
                pulses = 0;
                for (int i = 0; i < NS; i++) begin
                    if (stim_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL load_slot%0d: load with no stimulus expected", i);
                    end else begin
                        e = stim_q.pop_front();
                        chk($sformatf("load_slot%0d", i), stim_mem[i], e);
                    end
                end
            end
            if (get_emu) begin
                chk("get_width", prev_get, 0);
                chk("clk_dut_low_cycles", lo_run - 1, LO);
                chk("pulses_per_vector", pulses, 1);
                pulses = 0;
            end
            if (have_prev && prev_valid && !prev_ready) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", m_data, prev_data);
            end
            if (vc_pending) begin
                chk("vec_count", vec_count, 16'(exp_vec));
                vc_pending = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_data: got 0x%0h with no byte expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e);
                    $display("out byte %0d of vector %0d: 0x%02h", out_cnt, exp_vec, m_data);
                end
                out_cnt++;
                if (out_cnt == NO) begin
                    out_cnt = 0;
                    exp_vec++;
                    vc_pending = 1'b1;
                end
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_load  = load_emu;
            prev_get   = get_emu;
            have_prev  = 1'b1;
        end
    end

    // Send one vector; gap < 0 picks a random 0..2 cycle gap after each byte
    task automatic send_vector(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int gap);
        logic [7:0] v[NS];
        int n;
        int g;
        v[0] = b0; v[1] = b1; v[2] = b2;
        for (int i = 0; i < NS; i++) begin
            n = 0;
            s_data  = v[i];
            s_valid = 1'b1;
            while (!s_ready && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (!s_ready) begin
                checks++; errors++;
                $display("FAIL s_ready_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
                s_valid = 1'b0;
                return;
            end
            if (i == 0) chk("busy_idle", busy, 0);
            @(posedge clk); #1;
            stim_q.push_back(v[i]);
            s_valid = 1'b0;
            if (i == 0) chk("busy_after_first", busy, 1);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(posedge clk); #1;
            end
        end
        for (int j = 0; j < NO; j++) exp_q.push_back(ref_out(v[0], v[1], v[2], j));
        $display("vector in: %02h %02h %02h", v[0], v[1], v[2]);
    endtask

    task automatic send_random();
        send_vector(8'($urandom), 8'($urandom), 8'($urandom), -1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vc_pending) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || vc_pending) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_din", Din_emu, 0);
        chk("rst_addr", Addr_emu, 0);
        chk("rst_load", load_emu, 0);
        chk("rst_get", get_emu, 0);
        chk("rst_clk_dut", clk_dut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vec_count", vec_count, 0);
        reset = 1'b0;

        send_vector(8'h0A, 8'h00, 8'h00, 0);
        send_vector(8'h11, 8'h22, 8'h33, 2);
        for (int k = 0; k < 30; k++) send_random();
        drain();

        // Abort a vector while clk_dut is high
        send_random();
        n = 0;
        while (!clk_dut && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!clk_dut) begin
            checks++; errors++;
            $display("FAIL clk_dut_timeout: clk_dut=%b, required 1", clk_dut);
        end
        reset = 1'b1;
        #1;
        chk("abort_clk_dut", clk_dut, 0);
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_vec_count", vec_count, 0);
        exp_q.delete();
        stim_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 12; k++) send_random();
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("final_vec_count", vec_count, 16'(exp_vec));
        chk("final_busy", busy, 0);
        chk("final_s_ready", s_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
